// File: rtl/sum_bcd_display.sv
// Captures a 5-bit sum, converts it to two BCD digits with a sequential
// double-dabble engine, and scans them onto a 2-digit common-anode display.
module sum_bcd_display #(
    parameter int REFRESH_CYCLES = 100000,
    parameter bit LEADING_BLANK  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sum_in,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t     state, state_next;
    logic [4:0] shift_reg, shift_next;
    logic [7:0] scratch, scratch_next;
    logic [2:0] count, count_next;
    logic [3:0] tens_next, ones_next;
    logic       busy_next, done_next;
    logic [3:0] adj_hi, adj_lo;

    logic [CW-1:0] refresh_cnt;
    logic          digit_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            tens      <= '0;
            ones      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            scratch   <= scratch_next;
            count     <= count_next;
            tens      <= tens_next;
            ones      <= ones_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // Digits are only published in UPDATE, so the display never sees a partial result.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        scratch_next = scratch;
        count_next   = count;
        tens_next    = tens;
        ones_next    = ones;
        busy_next    = busy;
        done_next    = 1'b0;
        adj_hi       = (scratch[7:4] >= 4'd5) ? scratch[7:4] + 4'd3 : scratch[7:4];
        adj_lo       = (scratch[3:0] >= 4'd5) ? scratch[3:0] + 4'd3 : scratch[3:0];
        case (state)
            IDLE: begin
                if (load) begin
                    shift_next   = sum_in;
                    scratch_next = '0;
                    count_next   = '0;
                    busy_next    = 1'b1;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_next, shift_next} = {adj_hi, adj_lo, shift_reg} << 1;
                count_next = count + 3'd1;
                if (count == 3'd4) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                tens_next  = scratch[7:4];
                ones_next  = scratch[3:0];
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_sel   <= 1'b0;
        end else if (refresh_cnt == CW'(REFRESH_CYCLES - 1)) begin
            refresh_cnt <= '0;
            digit_sel   <= ~digit_sel;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        an  = 2'b10;
        seg = decode(ones);
        if (digit_sel) begin
            seg = decode(tens);
            an  = (LEADING_BLANK && tens == 4'd0) ? 2'b11 : 2'b01;
        end
    end

endmodule

// File: tb/tb_sum_bcd_display.sv
// Self-checking bench for sum_bcd_display: vector table, hand-written corner
// sequences, and random loads against an arithmetic reference model.
module tb_sum_bcd_display;

    localparam int R = 4;

    logic       clk;
    logic       rst;
    logic [4:0] sum_in;
    logic       load;
    logic       busy;
    logic       done;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg;
    logic [1:0] an;

    int checks = 0;
    int fails  = 0;
    int edges  = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    typedef struct {
        logic [4:0] sum;
        logic [3:0] tens;
        logic [3:0] ones;
        logic [6:0] seg_ones;
        logic [6:0] seg_tens;
        logic [1:0] an_tens;
    } vec_t;

    vec_t vecs [8];

    sum_bcd_display #(.REFRESH_CYCLES(R), .LEADING_BLANK(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .sum_in (sum_in),
        .load   (load),
        .busy   (busy),
        .done   (done),
        .tens   (tens),
        .ones   (ones),
        .seg    (seg),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference scan position: clock edges since reset released.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] v, output int lat, output int busy_cycles);
        @(negedge clk);
        sum_in = v;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load        = 1'b0;
        sum_in      = 5'($urandom);
        lat         = -1;
        busy_cycles = busy ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic checkDisplay(input string tag, input logic [6:0] seg_o, input logic [6:0] seg_t,
                                input logic [1:0] an_t);
        for (int k = 0; k < 2 * R; k++) begin
            @(negedge clk);
            if (((edges / R) % 2) == 0) begin
                checkOutput({tag, "_an_ones"}, an, 2'b10);
                checkOutput({tag, "_seg_ones"}, seg, seg_o);
            end else begin
                checkOutput({tag, "_an_tens"}, an, an_t);
                if (an_t == 2'b01) checkOutput({tag, "_seg_tens"}, seg, seg_t);
            end
        end
    endtask

    initial begin
        int lat, bc, dones, v;
        bit saw01;

        rst    = 1'b1;
        load   = 1'b0;
        sum_in = 5'd0;

        vecs[0] = '{5'd0,  4'd0, 4'd0, 7'b1000000, 7'b1000000, 2'b11};
        vecs[1] = '{5'd7,  4'd0, 4'd7, 7'b1111000, 7'b1000000, 2'b11};
        vecs[2] = '{5'd9,  4'd0, 4'd9, 7'b0010000, 7'b1000000, 2'b11};
        vecs[3] = '{5'd10, 4'd1, 4'd0, 7'b1000000, 7'b1111001, 2'b01};
        vecs[4] = '{5'd19, 4'd1, 4'd9, 7'b0010000, 7'b1111001, 2'b01};
        vecs[5] = '{5'd25, 4'd2, 4'd5, 7'b0010010, 7'b0100100, 2'b01};
        vecs[6] = '{5'd30, 4'd3, 4'd0, 7'b1000000, 7'b0110000, 2'b01};
        vecs[7] = '{5'd31, 4'd3, 4'd1, 7'b1111001, 7'b0110000, 2'b01};

        #2;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_tens", tens, 0);
        checkOutput("reset_ones", ones, 0);
        checkOutput("reset_an", an, 2'b10);
        checkOutput("reset_seg", seg, 7'b1000000);
        #10;
        rst = 1'b0;

        applyStimulus(5'd30, lat, bc);
        checkOutput("max_latency", lat, 6);
        checkOutput("max_busy_cycles", bc, 6);
        checkOutput("max_tens", tens, 3);
        checkOutput("max_ones", ones, 0);
        checkOutput("max_busy_low_at_done", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("max_done_fall", done, 0);
        checkDisplay("max", seg_tab[0], 7'b0110000, 2'b01);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].sum, lat, bc);
            checkOutput("vec_latency", lat, 6);
            checkOutput("vec_tens", tens, vecs[i].tens);
            checkOutput("vec_ones", ones, vecs[i].ones);
            checkDisplay("vec", vecs[i].seg_ones, vecs[i].seg_tens, vecs[i].an_tens);
        end

        // Second load arrives while busy and must be dropped.
        @(negedge clk);
        sum_in = 5'd19;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sum_in = 5'd5;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checkOutput("overlap_done_pulses", dones, 1);
        checkOutput("overlap_tens", tens, 1);
        checkOutput("overlap_ones", ones, 9);

        applyStimulus(5'd25, lat, bc);
        checkOutput("scan_latency", lat, 6);
        checkDisplay("scan_a", 7'b0010010, 7'b0100100, 2'b01);
        checkDisplay("scan_b", 7'b0010010, 7'b0100100, 2'b01);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        sum_in = 5'd22;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_tens", tens, 0);
        checkOutput("midrst_ones", ones, 0);
        checkOutput("midrst_an", an, 2'b10);
        checkOutput("midrst_seg", seg, 7'b1000000);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checkOutput("midrst_no_done", dones, 0);
        checkOutput("midrst_tens_held", tens, 0);
        applyStimulus(5'd22, lat, bc);
        checkOutput("midrst_reload_latency", lat, 6);
        checkOutput("midrst_reload_tens", tens, 2);
        checkOutput("midrst_reload_ones", ones, 2);

        saw01 = 1'b0;
        for (int s = 0; s < 32; s++) begin
            applyStimulus(5'(s), lat, bc);
            checkOutput("sweep_value", tens * 10 + ones, s);
            if (s == 7) begin
                for (int k = 0; k < 3 * R; k++) begin
                    @(negedge clk);
                    if (an == 2'b01) saw01 = 1'b1;
                end
                checkOutput("sweep7_tens_blanked", saw01, 0);
            end
        end

        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 31));
            applyStimulus(5'(v), lat, bc);
            checkOutput("rand_latency", lat, 6);
            checkOutput("rand_tens", tens, v / 10);
            checkOutput("rand_ones", ones, v % 10);
            checkDisplay("rand", seg_tab[v % 10], seg_tab[v / 10], (v / 10 == 0) ? 2'b11 : 2'b01);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sum_bcd_display.md
# sum_bcd_display

Downstream consumer of the registered 4-bit adder's 5-bit sum. Captures a sum value on a load strobe and converts it to two BCD digits with a sequential double-dabble engine. It drives a two-digit, time-multiplexed, common-anode seven-segment display with active-low segments and anodes. The adder's output range is 0–30, and the block accepts any 5-bit value (0–31).

## Interface
- REFRESH_CYCLES, 100000: clk cycles each digit stays lit before the scan advances; legal range ≥ 2.
- LEADING_BLANK, 1: when 1, the tens digit is blanked whenever it is 0.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sum_in  input  5  value to convert; sampled only on an accepted load.
- load  input  1  single-cycle request to capture sum_in; ignored while busy=1.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the display digits update.
- tens  output  4  BCD tens digit currently displayed (0–3).
- ones  output  4  BCD ones digit currently displayed (0–9).
- seg  output  7  active-low segments; seg[0]=a … seg[6]=g.
- an  output  2  active-low anodes; an[0]=ones digit, an[1]=tens digit.

## Operation
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE, load=1: capture sum_in into a 5-bit shift register, clear the 8-bit BCD scratch, set the shift count to 0, go to SHIFT.
- SHIFT, each cycle:
  - For each scratch nibble ≥5, add 3.
  - Then shift {scratch, shift register} left by 1.
  - Increment the count.
  - After the 5th shift, go to UPDATE.
- UPDATE: copy the scratch nibbles into tens/ones, pulse done, return to IDLE.
- busy=1 in SHIFT and UPDATE; busy=0 in IDLE.
- load in SHIFT or UPDATE is dropped, not queued. sum_in changes during conversion have no effect.
- tens/ones hold their value between conversions; the display never shows partial results.
- Scan engine:
  - Free-running refresh counter, width clog2(REFRESH_CYCLES), counting 0…REFRESH_CYCLES-1 then wrapping to 0.
  - On each wrap, toggle the digit select.
  - Select 0: an=2'b10, seg=decode(ones).
  - Select 1: an=2'b01, seg=decode(tens).
  - If LEADING_BLANK=1 and tens=0, an=2'b11 during select 1.
- Decoder, active-low (seg[6:0] = g…a): 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000. Any other code→1111111.
- The scan runs independently of the converter; conversion never stalls or resets the scan.

## Timing
- Reset values:
  - FSM=IDLE, busy=0, done=0, tens=0, ones=0.
  - Refresh counter=0, digit select=0, so an=2'b10 and seg=1000000 (shows "0").
- Latency:
  - load accepted at edge N; busy=1 after edge N.
  - Shifts occur at edges N+1…N+5.
  - At edge N+6, tens/ones update, done=1 and busy=0.
  - done falls at edge N+7. Total load-to-display latency is 6 cycles.
- The next load can be accepted at edge N+7 (busy sampled low).
- All outputs are registered except seg/an, which are combinational from registered select and digit values.
- Asynchronous rst mid-conversion: abort immediately, restore reset values, and do not pulse done on release.
- The digit-select change is visible the cycle after the counter wraps; each digit is lit for exactly REFRESH_CYCLES cycles.

## Test plan
- Reset: assert rst asynchronously between edges. Required: busy=0, done=0, tens=0, ones=0, an=2'b10, seg=1000000 immediately, with no clock.
- Load sum_in=30 (the adder's maximum, 15+15). Required: busy high for 6 cycles, done pulse exactly 6 cycles after load, then tens=3, ones=0, tens seg=0110000.
- Sweep: load every value 0–31 sequentially, waiting for done each time. Required: tens*10+ones equals sum_in for every value. With LEADING_BLANK=1 and value 7, an never shows 2'b01.
- Busy overlap: load=19, then load=5 two cycles later. Required: second load ignored, a single done pulse, display shows 1/9.
- Scan with REFRESH_CYCLES=4, displaying 25. Required: an alternates 10,10,10,10,01,01,01,01…; seg=0010010 (5) during 10 and seg=0100100 (2) during 01.
- Reset mid-conversion: load=22, assert rst at cycle 3. Required: no done pulse; tens=0, ones=0; the next load=22 completes normally with 2/2.
